// File: rtl/hazard_log_writer.sv
// Write side of the pipeline hazard log: detects RAW hazards between the ID
// operands and the EX/MEM producers and packs them into a 13-slot circular log.
module hazard_log_writer #(
  parameter int SLOTS = 13,
  parameter int REG_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_W-1:0]     id_rs1,
  input  logic [REG_W-1:0]     id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_wr_en,
  input  logic [REG_W-1:0]     ex_rd,
  input  logic                 mem_wr_en,
  input  logic [REG_W-1:0]     mem_rd,
  input  logic                 clear,
  input  logic                 freeze,
  output logic [8*SLOTS:0]     hazard_mem,
  output logic [3:0]           hazard_count,
  output logic [3:0]           wr_ptr,
  output logic                 hazard_pulse
);

  localparam logic [3:0] LAST_SLOT = 4'(SLOTS - 1);
  localparam logic [3:0] FULL_CNT  = 4'(SLOTS);
  localparam logic [4:0] FULL_CNT5 = 5'(SLOTS);

  logic [7:0] r_slots [SLOTS];
  logic       r_ovf;
  logic [3:0] r_count;
  logic [3:0] r_ptr;
  logic       r_pulse;

  logic       w_use1, w_use2;
  logic       w_ex1, w_mem1, w_ex2, w_mem2;
  logic       w_hit1, w_hit2;
  logic [1:0] w_nrec;
  logic [7:0] w_rec1, w_rec2;
  logic [3:0] w_ptr1, w_ptr2;
  logic [4:0] w_sum;
  logic       w_ovf;

  always_comb begin
    w_use1 = id_valid & id_use_rs1 & ~freeze & (id_rs1 != '0);
    w_use2 = id_valid & id_use_rs2 & ~freeze & (id_rs2 != '0);
    w_ex1  = ex_wr_en  & (ex_rd  == id_rs1);
    w_mem1 = mem_wr_en & (mem_rd == id_rs1);
    w_ex2  = ex_wr_en  & (ex_rd  == id_rs2);
    w_mem2 = mem_wr_en & (mem_rd == id_rs2);
    w_hit1 = w_use1 & (w_ex1 | w_mem1);
    // A second operand naming the same register adds no new information.
    w_hit2 = w_use2 & (w_ex2 | w_mem2) & ~(w_hit1 & (id_rs1 == id_rs2));
    w_rec1 = {id_rs1, 1'b0, (w_ex1 ? 2'b01 : 2'b10), 2'b01};
    w_rec2 = {id_rs2, 1'b1, (w_ex2 ? 2'b01 : 2'b10), 2'b01};
    w_nrec = {1'b0, w_hit1} + {1'b0, w_hit2};
    w_ptr1 = (r_ptr  == LAST_SLOT) ? 4'd0 : r_ptr + 4'd1;
    w_ptr2 = (w_ptr1 == LAST_SLOT) ? 4'd0 : w_ptr1 + 4'd1;
    w_sum  = {1'b0, r_count} + {3'b000, w_nrec};
    // Any write beyond a full log lands on the oldest record.
    w_ovf  = (w_sum > FULL_CNT5);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < SLOTS; k++) r_slots[k] <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
      r_ptr   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= (w_nrec != 2'd0);
      if (w_hit1) r_slots[r_ptr] <= w_rec1;
      if (w_hit2) r_slots[w_hit1 ? w_ptr1 : r_ptr] <= w_rec2;
      case (w_nrec)
        2'd1:    r_ptr <= w_ptr1;
        2'd2:    r_ptr <= w_ptr2;
        default: r_ptr <= r_ptr;
      endcase
      r_count <= w_ovf ? FULL_CNT : w_sum[3:0];
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  assign hazard_mem[8*SLOTS] = r_ovf;
  for (genvar k = 0; k < SLOTS; k++) begin : g_pack
    assign hazard_mem[8*(SLOTS-k)-1 -: 8] = r_slots[k];
  end

  assign hazard_count = r_count;
  assign wr_ptr       = r_ptr;
  assign hazard_pulse = r_pulse;

endmodule

// File: tb/tb_hazard_log_writer.sv
// Directed self-checking bench for hazard_log_writer.
module tb_hazard_log_writer;

  logic         clk = 1'b0;
  logic         rst, id_valid, id_use_rs1, id_use_rs2, ex_wr_en, mem_wr_en, clear, freeze;
  logic [2:0]   id_rs1, id_rs2, ex_rd, mem_rd;
  logic [104:0] hazard_mem;
  logic [3:0]   hazard_count, wr_ptr;
  logic         hazard_pulse;

  int           nChecks = 0;
  int           nFails  = 0;
  logic [104:0] expMem;

  hazard_log_writer dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_wr_en(ex_wr_en), .ex_rd(ex_rd),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .clear(clear), .freeze(freeze),
    .hazard_mem(hazard_mem), .hazard_count(hazard_count), .wr_ptr(wr_ptr),
    .hazard_pulse(hazard_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rec(input logic [2:0] r, input logic op, input logic [1:0] st);
    return {r, op, st, 2'b01};
  endfunction

  task automatic setExp(input int k, input logic [7:0] v);
    expMem[103-8*k -: 8] = v;
  endtask

  // Drive one cycle of ID/EX/MEM inputs and land 1ns after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [2:0] r1, input logic u1,
                               input logic [2:0] r2, input logic u2,
                               input logic exEn, input logic [2:0] exRd,
                               input logic memEn, input logic [2:0] memRd);
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    ex_wr_en = exEn; ex_rd = exRd; mem_wr_en = memEn; mem_rd = memRd;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic doClear();
    clear = 1'b1; idle(); clear = 1'b0;
    expMem = '0;
  endtask

  // Single rs1 hazard number i; even i from EX, odd i from MEM with EX on another reg.
  task automatic singleHazard(input int i);
    logic [2:0] r;
    r = 3'((i % 7) + 1);
    if (i % 2 == 0) applyStimulus(1'b1, r, 1'b1, 3'd0, 1'b0, 1'b1, r, 1'b0, 3'd0);
    else            applyStimulus(1'b1, r, 1'b1, 3'd0, 1'b0, 1'b1, r ^ 3'b111, 1'b1, r);
    setExp(i % 13, rec(r, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10));
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); rst = 1'b0;
    nChecks++;
    if (hazard_mem !== 105'd0 || hazard_count !== 4'd0 || wr_ptr !== 4'd0 || hazard_pulse !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_state: mem=%h cnt=%0d ptr=%0d pulse=%b required all zero",
               hazard_mem, hazard_count, wr_ptr, hazard_pulse);
    end
    for (int c = 0; c < 5; c++) begin
      idle();
      nChecks++;
      if (hazard_pulse !== 1'b0 || hazard_count !== 4'd0 || wr_ptr !== 4'd0 || hazard_mem !== 105'd0) begin
        nFails++;
        $display("[TB] FAIL reset_idle%0d: mem=%h cnt=%0d ptr=%0d pulse=%b required all zero",
                 c, hazard_mem, hazard_count, wr_ptr, hazard_pulse);
      end
    end
  endtask

  task automatic test_single_ex();
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    nChecks++;
    if (hazard_mem[103:96] !== 8'h65) begin
      nFails++; $display("[TB] FAIL single_slot0: actual=%h required=65", hazard_mem[103:96]);
    end
    nChecks++;
    if (hazard_count !== 4'd1 || wr_ptr !== 4'd1 || hazard_pulse !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL single_state: cnt=%0d ptr=%0d pulse=%b required 1 1 1",
               hazard_count, wr_ptr, hazard_pulse);
    end
    idle();
    nChecks++;
    if (hazard_pulse !== 1'b0) begin
      nFails++; $display("[TB] FAIL single_pulse_drop: actual=%b required=0", hazard_pulse);
    end
  endtask

  task automatic test_dual();
    doClear();
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b1, 3'd2, 1'b1, 3'd5);
    nChecks++;
    if (hazard_mem[103:88] !== 16'h45B9) begin
      nFails++; $display("[TB] FAIL dual_slots: actual=%h required=45b9", hazard_mem[103:88]);
    end
    nChecks++;
    if (hazard_count !== 4'd2 || wr_ptr !== 4'd2 || hazard_pulse !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL dual_state: cnt=%0d ptr=%0d pulse=%b required 2 2 1",
               hazard_count, wr_ptr, hazard_pulse);
    end
    // Same register on both operands yields one record.
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 1'b1, 3'd5);
    nChecks++;
    if (hazard_mem[87:72] !== 16'h4500 || hazard_count !== 4'd3 || wr_ptr !== 4'd3) begin
      nFails++;
      $display("[TB] FAIL same_reg: slots2_3=%h cnt=%0d ptr=%0d required 4500 3 3",
               hazard_mem[87:72], hazard_count, wr_ptr);
    end
    // EX beats MEM when both produce the register; rs2 alone still logs as operand 1.
    applyStimulus(1'b1, 3'd4, 1'b0, 3'd4, 1'b1, 1'b1, 3'd4, 1'b1, 3'd4);
    nChecks++;
    if (hazard_mem[79:72] !== 8'h95 || wr_ptr !== 4'd4) begin
      nFails++;
      $display("[TB] FAIL ex_priority: slot3=%h ptr=%0d required 95 4", hazard_mem[79:72], wr_ptr);
    end
  endtask

  task automatic test_reg0_freeze();
    doClear();
    applyStimulus(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 3'd0);
    nChecks++;
    if (hazard_mem !== 105'd0 || hazard_count !== 4'd0 || hazard_pulse !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reg0: mem=%h cnt=%0d pulse=%b required 0 0 0", hazard_mem, hazard_count, hazard_pulse);
    end
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    setExp(0, 8'h65);
    freeze = 1'b1;
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b1, 3'd2, 1'b1, 3'd5);
    nChecks++;
    if (hazard_mem !== expMem || hazard_count !== 4'd1 || wr_ptr !== 4'd1 || hazard_pulse !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL freeze_hold: mem=%h cnt=%0d ptr=%0d pulse=%b required mem=%h 1 1 0",
               hazard_mem, hazard_count, wr_ptr, hazard_pulse, expMem);
    end
    clear = 1'b1;
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b1, 3'd2, 1'b1, 3'd5);
    clear = 1'b0; freeze = 1'b0; expMem = '0;
    nChecks++;
    if (hazard_mem !== 105'd0 || hazard_count !== 4'd0 || wr_ptr !== 4'd0) begin
      nFails++;
      $display("[TB] FAIL freeze_clear: mem=%h cnt=%0d ptr=%0d required 0 0 0", hazard_mem, hazard_count, wr_ptr);
    end
  endtask

  task automatic test_wrap();
    doClear();
    for (int i = 0; i < 13; i++) singleHazard(i);
    nChecks++;
    if (hazard_mem !== expMem || hazard_count !== 4'd13 || wr_ptr !== 4'd0) begin
      nFails++;
      $display("[TB] FAIL wrap_full: mem=%h cnt=%0d ptr=%0d required mem=%h 13 0",
               hazard_mem, hazard_count, wr_ptr, expMem);
    end
    singleHazard(13);
    expMem[104] = 1'b1;
    nChecks++;
    if (hazard_mem !== expMem || hazard_count !== 4'd13 || wr_ptr !== 4'd1) begin
      nFails++;
      $display("[TB] FAIL wrap_overwrite: mem=%h cnt=%0d ptr=%0d required mem=%h 13 1",
               hazard_mem, hazard_count, wr_ptr, expMem);
    end
    for (int i = 14; i < 25; i++) singleHazard(i);
    applyStimulus(1'b1, 3'd6, 1'b1, 3'd1, 1'b1, 1'b1, 3'd6, 1'b1, 3'd1);
    setExp(12, 8'hC5); setExp(0, 8'h39);
    nChecks++;
    if (hazard_mem !== expMem || hazard_count !== 4'd13 || wr_ptr !== 4'd1) begin
      nFails++;
      $display("[TB] FAIL wrap_dual12: mem=%h cnt=%0d ptr=%0d required mem=%h 13 1",
               hazard_mem, hazard_count, wr_ptr, expMem);
    end
  endtask

  task automatic test_pair_wrap();
    doClear();
    for (int i = 0; i < 11; i++) singleHazard(i);
    applyStimulus(1'b1, 3'd6, 1'b1, 3'd1, 1'b1, 1'b1, 3'd6, 1'b1, 3'd1);
    setExp(11, 8'hC5); setExp(12, 8'h39);
    nChecks++;
    if (hazard_mem !== expMem || hazard_count !== 4'd13 || wr_ptr !== 4'd0) begin
      nFails++;
      $display("[TB] FAIL pair_11: mem=%h cnt=%0d ptr=%0d required mem=%h 13 0",
               hazard_mem, hazard_count, wr_ptr, expMem);
    end
    doClear();
    for (int i = 0; i < 12; i++) singleHazard(i);
    applyStimulus(1'b1, 3'd6, 1'b1, 3'd1, 1'b1, 1'b1, 3'd6, 1'b1, 3'd1);
    setExp(12, 8'hC5); setExp(0, 8'h39); expMem[104] = 1'b1;
    nChecks++;
    if (hazard_mem !== expMem || hazard_count !== 4'd13 || wr_ptr !== 4'd1) begin
      nFails++;
      $display("[TB] FAIL pair_midovf: mem=%h cnt=%0d ptr=%0d required mem=%h 13 1",
               hazard_mem, hazard_count, wr_ptr, expMem);
    end
  endtask

  task automatic test_clear_priority();
    clear = 1'b1;
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    clear = 1'b0;
    nChecks++;
    if (hazard_mem !== 105'd0 || hazard_count !== 4'd0 || wr_ptr !== 4'd0 || hazard_pulse !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL clear_priority: mem=%h cnt=%0d ptr=%0d pulse=%b required all zero",
               hazard_mem, hazard_count, wr_ptr, hazard_pulse);
    end
  endtask

  task automatic test_rst_with_hazard();
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b1, 3'd2, 1'b1, 3'd5);
    rst = 1'b0;
    nChecks++;
    if (hazard_mem !== 105'd0 || hazard_count !== 4'd0 || wr_ptr !== 4'd0 || hazard_pulse !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rst_hazard: mem=%h cnt=%0d ptr=%0d pulse=%b required all zero",
               hazard_mem, hazard_count, wr_ptr, hazard_pulse);
    end
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; freeze = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_wr_en = 1'b0; ex_rd = '0; mem_wr_en = 1'b0; mem_rd = '0;
    expMem = '0;
    test_reset();
    test_single_ex();
    test_dual();
    test_reg0_freeze();
    test_wrap();
    test_pair_wrap();
    test_clear_priority();
    test_rst_with_hazard();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/hazard_log_writer.md
Name: hazard_log_writer

Overview:
- Write side of the pipeline hazard log. Samples the ID-stage source operands against the EX and MEM destination registers and detects RAW hazards.
- Packs each hazard into an 8-bit record in a 13-slot circular log, presented as a flat 105-bit vector (hazard_mem).
- The log display/decoder consumes hazard_mem combinationally. This block is the only writer of that vector.

Parameters:
- SLOTS, 13, number of 8-bit record slots in hazard_mem (fixed by the 105-bit vector format).
- REG_W, 3, register index width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID-stage instruction valid this cycle.
- id_rs1  input  3  ID source register 1.
- id_rs2  input  3  ID source register 2.
- id_use_rs1  input  1  instruction reads rs1.
- id_use_rs2  input  1  instruction reads rs2.
- ex_wr_en  input  1  EX-stage instruction writes a register.
- ex_rd  input  3  EX-stage destination register.
- mem_wr_en  input  1  MEM-stage instruction writes a register.
- mem_rd  input  3  MEM-stage destination register.
- clear  input  1  synchronous log clear (same effect as rst on log state).
- freeze  input  1  hold the log; no captures while high.
- hazard_mem  output  105  flattened log. Slot k occupies [103-8k : 96-8k], k=0..12. Bit 104 = overflow flag.
- hazard_count  output  4  number of valid records, saturates at 13.
- wr_ptr  output  4  next slot to write, range 0..12.
- hazard_pulse  output  1  registered, high one cycle after a cycle in which at least one record was written.

Behaviour:
- Reset (rst=1 at a clock edge): hazard_mem=0, hazard_count=0, wr_ptr=0, hazard_pulse=0. All-zero slot = empty.
- Record format:
  - [7:5] hazarded register.
  - [4] operand (0=rs1, 1=rs2).
  - [3:2] producer stage (01=EX, 10=MEM).
  - [1:0] = 2'b01 valid marker.
- Detection per operand X in {rs1, rs2}, evaluated when id_valid & id_use_X & !freeze:
  - Register 0 never hazards.
  - Hit EX if ex_wr_en & ex_rd==X.
  - Otherwise hit MEM if mem_wr_en & mem_rd==X.
  - EX has priority (most recent producer). Only one record per operand.
- Same-register case: if both operands are used, id_rs1==id_rs2 and it hazards, log one record only (operand bit 0).
- Writes per cycle: 0, 1 or 2.
  - With one record, write it at wr_ptr.
  - With two, write rs1 at wr_ptr and rs2 at (wr_ptr+1) mod 13.
  - wr_ptr advances by the number written, mod 13 (12+1→0, 12+2→1, 11+2→0).
- Count: hazard_count += records written, saturating at 13.
- Overflow: writing into an occupied slot (count already 13, or count reaching 13 mid-pair) overwrites the oldest record and sets bit 104. Bit 104 is sticky until rst or clear.
- Latency: a record sampled at edge N is visible on hazard_mem after edge N. hazard_pulse is high for the cycle following edge N.
- clear:
  - Same-edge effect as rst on hazard_mem, count, wr_ptr and pulse.
  - Has priority over any capture in the same cycle; that cycle's hazards are dropped.
- freeze: log, count, wr_ptr and bit 104 hold; hazard_pulse=0. clear still acts while frozen.
- rst mid-pair, or with a simultaneous hazard: rst wins and nothing is written.
- Unused bits: none. All 105 bits are defined.

Test Plan:
- Reset, then idle 5 cycles -> hazard_mem=0, count=0, wr_ptr=0, pulse never high.
- ex_wr_en=1, ex_rd=3, id_rs1=3 used, id_valid=1 -> next cycle slot0 [103:96]=8'b011_0_01_01, count=1, wr_ptr=1, pulse=1.
- ex_rd=2 and mem_rd=5 (both write enabled), rs1=2, rs2=5 both used -> slot0=8'b010_0_01_01, slot1=8'b101_1_10_01, wr_ptr=2, count=2. Repeat with rs1=rs2=2 -> single record only.
- Rs1 = 0 with ex_rd=0 and ex_wr_en=1 -> no record, pulse=0. With freeze=1 and a valid hazard -> no change.
- 14 single hazards -> wr_ptr wraps 12→0, slot0 overwritten by the 14th record, count=13, bit 104=1. Dual hazard at wr_ptr=12 -> slots 12 and 0 written, wr_ptr=1.
- clear asserted in the same cycle as a hazard, after the log is full -> hazard_mem=0 (bit 104 cleared), count=0, wr_ptr=0, hazard dropped.
